// File: rtl/dffrn_stim_pkg.sv
// Shared types and constants for the DFFRN stimulus/check stage.
package dffrn_stim_pkg;

  localparam int          LFSR_W       = 8;
  // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting register: bits 7,5,4,3
  localparam logic [7:0]  LFSR_TAPS    = 8'hB8;
  localparam logic [7:0]  SEED_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, FIN} state_t;

  // One Fibonacci step: shift left, XOR of the tapped bits enters at bit 0
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/dffrn_stim_lfsr.sv
// 8-bit vector generator. Exposes the D and RN bits of the value the register
// will hold after this edge, so the top can register the cell pins in step.
module dffrn_stim_lfsr
  import dffrn_stim_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = SEED_DEFAULT
) (
  input  logic clk,
  input  logic r,
  input  logic load,
  input  logic advance,
  output logic d_bit,
  output logic rn_bit
);

  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] upcoming;

  // Next register value: reload wins over advance, otherwise hold
  always_comb begin
    upcoming = lfsr;
    if (load)         upcoming = SEED;
    else if (advance) upcoming = lfsr_step(lfsr);
  end

  assign d_bit  = upcoming[0];
  assign rn_bit = |upcoming[3:1];

  // State register
  always_ff @(posedge clk) begin
    if (r) lfsr <= SEED;
    else   lfsr <= upcoming;
  end

endmodule

// File: rtl/dffrn_stim_chk.sv
// Stimulus/check stage for one DFFRN cell: four CLK phases per vector,
// CLKN pulses high for P1..P2, response sampled at end of P2, checked in P3.
module dffrn_stim_chk
  import dffrn_stim_pkg::*;
#(
  parameter int                PAT_LEN = 16,
  parameter int                CNT_W   = 16,
  parameter logic [LFSR_W-1:0] SEED    = SEED_DEFAULT
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic             dut_d,
  output logic             dut_rn,
  output logic             dut_clkn,
  input  logic             dut_q,
  input  logic             dut_qn
);

  state_t      state, state_nxt;
  logic [15:0] vec;
  logic        exp_q, q_smp, qn_smp;
  logic        load, advance, last_vec, mismatch;
  logic        nxt_d, nxt_rn;

  assign load     = (state == IDLE) && start;
  assign advance  = (state == P3);
  assign last_vec = (vec == 16'(PAT_LEN - 1));
  assign mismatch = (q_smp != exp_q) || (qn_smp != ~exp_q);

  dffrn_stim_lfsr #(.SEED(SEED)) u_lfsr (
    .clk     (CLK),
    .r       (R),
    .load    (load),
    .advance (advance),
    .d_bit   (nxt_d),
    .rn_bit  (nxt_rn)
  );

  // Next-state: fixed four-phase walk per vector, FIN for one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = P0;
      P0:      state_nxt = P1;
      P1:      state_nxt = P2;
      P2:      state_nxt = P3;
      P3:      state_nxt = last_vec ? FIN : P0;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (R) state <= IDLE;
    else   state <= state_nxt;
  end

  // Run control, sampling, compare, and registered cell pins keyed on the
  // state being entered so every pin changes exactly at a CLK edge
  always_ff @(posedge CLK) begin
    if (R) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      vec      <= '0;
      exp_q    <= 1'b0;
      q_smp    <= 1'b0;
      qn_smp   <= 1'b0;
      dut_d    <= 1'b0;
      dut_rn   <= 1'b0;
      dut_clkn <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy    <= 1'b1;
          pass    <= 1'b0;
          err_cnt <= '0;
          vec     <= '0;
        end
        P2: begin
          q_smp  <= dut_q;
          qn_smp <= dut_qn;
        end
        P3: begin
          if (mismatch && (err_cnt != {CNT_W{1'b1}})) err_cnt <= err_cnt + 1'b1;
          vec <= vec + 16'd1;
        end
        FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
          pass <= (err_cnt == '0);
        end
        default: ;
      endcase

      dut_clkn <= (state_nxt == P1) || (state_nxt == P2);
      if (state_nxt == P0) begin
        // RN (re)asserts here, a full CLK ahead of the CLKN rising edge
        dut_d  <= nxt_d;
        dut_rn <= nxt_rn;
        exp_q  <= nxt_rn & nxt_d;
      end else if ((state_nxt == IDLE) || (state_nxt == FIN)) begin
        dut_d  <= 1'b0;
        dut_rn <= 1'b0;
      end
    end
  end

endmodule
